// File: rtl/seg_scan_if.sv
// Purpose: display-side bundle for seg_scan (BCD time and display options in, digit/segment drive out).
// Latency: none, pure wiring.
// Backpressure: none; the display consumes whatever is presented.
//   hour/min/sec   BCD time {tens,ones}
//   time_mode      0 = 24 h, 1 = 12 h
//   blink_sel      field blink enables {hour,min,sec}
//   blank          1 = all digits dark
//   select_light   digit enables, bit7 = leftmost digit
//   display_char   segments {a,b,c,d,e,f,g,dp}
interface seg_scan_if;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       time_mode;
    logic [2:0] blink_sel;
    logic       blank;
    logic [7:0] select_light;
    logic [7:0] display_char;

    modport master (
        output hour, min, sec, time_mode, blink_sel, blank,
        input  select_light, display_char
    );

    modport slave (
        input  hour, min, sec, time_mode, blink_sel, blank,
        output select_light, display_char
    );
endinterface

// File: rtl/seg_scan.sv
// Purpose: time-multiplexed 8-digit seven-segment driver rendering HH-MM-SS with 12/24 h and field blink.
// Latency: outputs registered on scan ticks (every DIV cycles); input change visible within 8*DIV cycles.
// Backpressure: none; free-running scan, blank darkens outputs while scanning continues.
//   CP            system clock, all state on rising edge
//   _CR           asynchronous active-low reset
//   bus (slave)   time/options in, select_light/display_char out
module seg_scan #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic        CP,
    input  logic        _CR,
    seg_scan_if.slave   bus
);
    localparam int DIV  = CLK_HZ / SCAN_HZ;
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW   = $clog2(DIV);
    localparam int BW   = $clog2(HALF);

    logic [PW-1:0] pre_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [2:0]    idx;
    logic [7:0]    sh_hour, sh_min, sh_sec;
    logic          sh_tm;

    logic          tick;
    logic          blink_wrap;
    logic [7:0]    f_hour, f_min, f_sec;
    logic          f_tm;
    logic [7:0]    disp_hour;
    logic          pm;
    logic [3:0]    nib;
    logic          is_dash;
    logic          field_blink;
    logic          dp;
    logic [7:0]    seg_code;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE0;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    assign tick       = (pre_cnt == PW'(DIV - 1));
    assign blink_wrap = (blink_cnt == BW'(HALF - 1));

    // The idx7 tick both takes the snapshot and renders from it, so that
    // digit reads the live inputs; the rest of the frame reads the shadow.
    always_comb begin
        if (idx == 3'd7) begin
            f_hour = bus.hour;
            f_min  = bus.min;
            f_sec  = bus.sec;
            f_tm   = bus.time_mode;
        end else begin
            f_hour = sh_hour;
            f_min  = sh_min;
            f_sec  = sh_sec;
            f_tm   = sh_tm;
        end
    end

    // 12 h conversion done directly on BCD digits; out-of-range hours pass through.
    always_comb begin
        disp_hour = f_hour;
        pm        = (f_hour >= 8'h12);
        if (f_tm && (f_hour[7:4] <= 4'd9) && (f_hour[3:0] <= 4'd9)) begin
            if (f_hour == 8'h00)
                disp_hour = 8'h12;
            else if ((f_hour >= 8'h13) && (f_hour <= 8'h19))
                disp_hour = {4'h0, f_hour[3:0] - 4'd2};
            else if ((f_hour == 8'h20) || (f_hour == 8'h21))
                disp_hour = {4'h0, f_hour[3:0] + 4'd8};
            else if ((f_hour == 8'h22) || (f_hour == 8'h23))
                disp_hour = {4'h1, f_hour[3:0] - 4'd2};
        end
    end

    always_comb begin
        nib         = 4'h0;
        is_dash     = 1'b0;
        field_blink = 1'b0;
        dp          = 1'b0;
        case (idx)
            3'd7: begin nib = disp_hour[7:4]; field_blink = bus.blink_sel[2]; end
            3'd6: begin
                nib         = disp_hour[3:0];
                field_blink = bus.blink_sel[2];
                dp          = f_tm & pm;
            end
            3'd5: is_dash = 1'b1;
            3'd4: begin nib = f_min[7:4]; field_blink = bus.blink_sel[1]; end
            3'd3: begin nib = f_min[3:0]; field_blink = bus.blink_sel[1]; end
            3'd2: is_dash = 1'b1;
            3'd1: begin nib = f_sec[7:4]; field_blink = bus.blink_sel[0]; end
            default: begin nib = f_sec[3:0]; field_blink = bus.blink_sel[0]; end
        endcase

        if (is_dash)
            seg_code = 8'h02;
        else if (blink_phase && field_blink)
            seg_code = 8'h00;
        else
            seg_code = seg7(nib) | {7'b0, dp};
    end

    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            pre_cnt          <= '0;
            blink_cnt        <= '0;
            blink_phase      <= 1'b0;
            idx              <= 3'd7;
            sh_hour          <= 8'h00;
            sh_min           <= 8'h00;
            sh_sec           <= 8'h00;
            sh_tm            <= 1'b0;
            bus.select_light <= 8'h00;
            bus.display_char <= 8'h00;
        end else begin
            pre_cnt   <= tick ? '0 : pre_cnt + PW'(1);
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
            // A toggle coinciding with a tick only affects later ticks.
            if (blink_wrap)
                blink_phase <= ~blink_phase;

            if (tick) begin
                idx <= idx - 3'd1;
                if (idx == 3'd7) begin
                    sh_hour <= bus.hour;
                    sh_min  <= bus.min;
                    sh_sec  <= bus.sec;
                    sh_tm   <= bus.time_mode;
                end
                bus.select_light <= bus.blank ? 8'h00 : (8'd1 << idx);
                bus.display_char <= bus.blank ? 8'h00 : seg_code;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// Purpose: self-checking bench for seg_scan: directed literal frames plus randomized inputs against a behavioural model.
// Latency: model predicts outputs per rising edge; compared on every falling edge.
// Backpressure: none.
module tb_seg_scan;
    localparam int CLK_HZ   = 16;
    localparam int SCAN_HZ  = 4;
    localparam int BLINK_HZ = 1;
    localparam int DIV      = CLK_HZ / SCAN_HZ;
    localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

    logic cp = 1'b0;
    logic cr_n;
    seg_scan_if bus ();

    seg_scan #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)) dut (
        .CP  (cp),
        ._CR (cr_n),
        .bus (bus)
    );

    always #5 cp = ~cp;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] lut [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    function automatic logic [7:0] seg_of(input int d);
        return (d > 9) ? 8'h00 : lut[d];
    endfunction

    // Tick number k (1-based) lands on edge 4k after release; digits run 7..0.
    function automatic int idx_of(input int nn);
        return 7 - ((nn / DIV - 1) % 8);
    endfunction

    // Phase in force at edge nn = number of completed half-periods before it, mod 2.
    function automatic bit phase_of(input int nn);
        return bit'(((nn - 1) / HALF) % 2);
    endfunction

    function automatic logic [7:0] render(input int i, input logic [7:0] hr, input logic [7:0] mn,
                                          input logic [7:0] sc, input bit tm, input logic [2:0] bs,
                                          input bit ph);
        int hb, h12, dt, dd, field;
        bit pm;
        if (i == 5 || i == 2) return 8'h02;
        field = (i >= 6) ? 2 : (i >= 3) ? 1 : 0;
        if (ph && bs[field]) return 8'h00;
        case (i)
            4: return seg_of(int'(mn[7:4]));
            3: return seg_of(int'(mn[3:0]));
            1: return seg_of(int'(sc[7:4]));
            0: return seg_of(int'(sc[3:0]));
            default: begin
                hb = int'(hr[7:4]) * 10 + int'(hr[3:0]);
                if (tm) begin
                    h12 = (hb % 12 == 0) ? 12 : hb % 12;
                    dt  = h12 / 10;
                    dd  = h12 % 10;
                    pm  = (hb >= 12);
                end else begin
                    dt = int'(hr[7:4]);
                    dd = int'(hr[3:0]);
                    pm = 1'b0;
                end
                if (i == 7) return seg_of(dt);
                return seg_of(dd) | {7'b0, pm};
            end
        endcase
    endfunction

    int         n;
    logic [7:0] sh_h, sh_m, sh_s;
    bit         sh_tm;
    logic [7:0] m_sel, m_ch;

    always @(posedge cp or negedge cr_n) begin
        if (!cr_n) begin
            n     <= 0;
            sh_h  <= 8'h00;
            sh_m  <= 8'h00;
            sh_s  <= 8'h00;
            sh_tm <= 1'b0;
            m_sel <= 8'h00;
            m_ch  <= 8'h00;
        end else begin
            n <= n + 1;
            if ((n + 1) % DIV == 0) begin
                m_sel <= bus.blank ? 8'h00 : 8'(1 << idx_of(n + 1));
                if (idx_of(n + 1) == 7) begin
                    sh_h  <= bus.hour;
                    sh_m  <= bus.min;
                    sh_s  <= bus.sec;
                    sh_tm <= bus.time_mode;
                    m_ch  <= bus.blank ? 8'h00 :
                             render(7, bus.hour, bus.min, bus.sec, bus.time_mode,
                                    bus.blink_sel, phase_of(n + 1));
                end else begin
                    m_ch  <= bus.blank ? 8'h00 :
                             render(idx_of(n + 1), sh_h, sh_m, sh_s, sh_tm,
                                    bus.blink_sel, phase_of(n + 1));
                end
            end
        end
    end

    always @(negedge cp) begin
        if (chk_en) begin
            check("model_sel", bus.select_light, m_sel);
            check("model_char", bus.display_char, m_ch);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick_chk(input string nm, input logic [7:0] sel, input logic [7:0] ch);
        repeat (DIV) @(negedge cp);
        check({nm, "_sel"}, bus.select_light, sel);
        check({nm, "_char"}, bus.display_char, ch);
    endtask

    task automatic skip_ticks(input int t);
        repeat (t * DIV) @(negedge cp);
    endtask

    task automatic release_and_first(input string nm, input logic [7:0] ch7);
        cr_n = 1'b1;
        for (int i = 0; i < DIV - 1; i++) begin
            @(negedge cp);
            check({nm, "_hold_sel"}, bus.select_light, 8'h00);
            check({nm, "_hold_char"}, bus.display_char, 8'h00);
        end
        @(negedge cp);
        check({nm, "_first_sel"}, bus.select_light, 8'h80);
        check({nm, "_first_char"}, bus.display_char, ch7);
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    logic [7:0] f1_sel [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] f1_ch  [8] = '{8'h60, 8'hDA, 8'h02, 8'hF2, 8'h66, 8'h02, 8'hB6, 8'hBE};

    initial begin
        cr_n          = 1'b0;
        bus.hour      = 8'h12;
        bus.min       = 8'h34;
        bus.sec       = 8'h56;
        bus.time_mode = 1'b0;
        bus.blink_sel = 3'b000;
        bus.blank     = 1'b0;
        repeat (2) @(negedge cp);
        chk_en = 1'b1;
        check("reset_sel", bus.select_light, 8'h00);
        check("reset_char", bus.display_char, 8'h00);

        // Frame 1 (ticks 1-8) and start of frame 2 (tick 9).
        release_and_first("t1", 8'h60);
        for (int i = 1; i < 8; i++) tick_chk($sformatf("f1_d%0d", i), f1_sel[i], f1_ch[i]);
        tick_chk("t9", 8'h80, 8'h60);
        tick_chk("t10", 8'h40, 8'hDA);
        tick_chk("t11", 8'h20, 8'h02);
        tick_chk("t12", 8'h10, 8'hF2);
        tick_chk("t13", 8'h08, 8'h66);

        // Mid-frame sec change: current frame stays on the snapshot.
        bus.sec = 8'h57;
        tick_chk("t14", 8'h04, 8'h02);
        tick_chk("t15", 8'h02, 8'hB6);
        tick_chk("sec_old", 8'h01, 8'hBE);

        // 12 h rendering of 13 -> " 1" PM.
        bus.time_mode = 1'b1;
        bus.hour      = 8'h13;
        tick_chk("h13_tens", 8'h80, 8'hFC);
        tick_chk("h13_ones", 8'h40, 8'h61);
        skip_ticks(5);
        tick_chk("sec_new", 8'h01, 8'hE0);

        // Midnight in 12 h -> 12 AM.
        bus.hour = 8'h00;
        tick_chk("h00_tens", 8'h80, 8'h60);
        tick_chk("h00_ones", 8'h40, 8'hDA);

        // Minute blink: tick 28 is in a phase-1 window, tick 29 is not.
        bus.blink_sel = 3'b010;
        tick_chk("blink_dash", 8'h20, 8'h02);
        tick_chk("blink_m10", 8'h10, 8'h00);
        tick_chk("blink_m1", 8'h08, 8'h66);
        tick_chk("blink_dash2", 8'h04, 8'h02);

        // Invalid minute ones nibble.
        bus.blink_sel = 3'b000;
        bus.min       = 8'h3A;
        skip_ticks(5);
        tick_chk("m3A_tens", 8'h10, 8'hF2);
        tick_chk("m3A_ones", 8'h08, 8'h00);

        // Blank keeps the scan running underneath.
        bus.blank = 1'b1;
        tick_chk("blank1", 8'h00, 8'h00);
        tick_chk("blank2", 8'h00, 8'h00);
        bus.blank = 1'b0;
        tick_chk("unblank", 8'h01, 8'hE0);
        skip_ticks(5);
        tick_chk("pre_rst", 8'h04, 8'h02);

        // Asynchronous reset mid-frame.
        #2 cr_n = 1'b0;
        #1;
        check("async_sel", bus.select_light, 8'h00);
        check("async_char", bus.display_char, 8'h00);
        @(negedge cp);
        @(negedge cp);
        release_and_first("rst2", 8'h60);

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            @(negedge cp);
            cr_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 15) == 0) bus.hour = to_bcd(int'($urandom_range(0, 23)));
            if ($urandom_range(0, 15) == 0)
                bus.min = ($urandom_range(0, 7) == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 59)));
            if ($urandom_range(0, 7) == 0) bus.sec = to_bcd(int'($urandom_range(0, 59)));
            if ($urandom_range(0, 31) == 0) bus.time_mode = 1'($urandom);
            if ($urandom_range(0, 31) == 0) bus.blink_sel = 3'($urandom);
            if ($urandom_range(0, 63) == 0) bus.blank = ($urandom_range(0, 3) == 0);
        end
        cr_n = 1'b1;
        repeat (4) @(negedge cp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed driver for the board's 8-digit seven-segment display, sitting directly downstream of `clock`. It consumes the BCD time `clock` produces (`pre_hour`/`pre_min`/`pre_sec`) and renders it as `HH-MM-SS`. Display options are 12/24-hour rendering and per-field blinking for the adjust mode. Its outputs drive the digit enables and segment lines.

## Interface
- `CLK_HZ`, 100_000_000, frequency of `CP` in Hz.
- `SCAN_HZ`, 1000, digit-advance rate in Hz. `DIV = CLK_HZ/SCAN_HZ` must be an integer ≥ 2.
- `BLINK_HZ`, 2, blink rate in Hz. `HALF = CLK_HZ/(2*BLINK_HZ)` must be an integer ≥ 2.
- `CP`  in  1  system clock; one clock domain, all state on rising edge.
- `_CR`  in  1  reset, asynchronous, active-low.
- `hour`  in  8  BCD hours 00–23, `{tens,ones}`.
- `min`  in  8  BCD minutes 00–59.
- `sec`  in  8  BCD seconds 00–59.
- `time_mode`  in  1  0 = 24 h display, 1 = 12 h display.
- `blink_sel`  in  3  field blink enable: bit2 = hour, bit1 = min, bit0 = sec.
- `blank`  in  1  1 = all digits dark.
- `select_light`  out  8  digit enables, active-high; bit7 = leftmost digit.
- `display_char`  out  8  segments `{a,b,c,d,e,f,g,dp}`, active-high.

## Operation
- Digit map, left to right:
  - idx7 = hour tens, idx6 = hour ones, idx5 = '-'
  - idx4 = min tens, idx3 = min ones, idx2 = '-'
  - idx1 = sec tens, idx0 = sec ones
- Scan counter `idx` (3 bits) steps 7→6→…→0→7. It advances once per scan tick.
- Scan tick is a `DIV`-cycle prescaler pulse, one cycle wide.
- Frame snapshot: on the tick that loads idx7, `hour`/`min`/`sec`/`time_mode` are captured into shadow registers. All eight digits of a frame render from the shadow, so there is no tearing. `blink_sel` and `blank` are sampled live on every tick.
- 12 h conversion, applied to the shadowed hour when `time_mode`=1:
  - 00 → 12
  - 01–12 → unchanged
  - 13–23 → hour−12, in BCD
  - PM = shadow hour ≥ 12; it lights dp on idx6.
  - A displayed 12 h tens digit of 0 is shown as 0, not suppressed.
- Segment codes: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, dash=02.
- Nibble > 9: segments 00 for that digit. dp is still applied on idx6.
- Blink phase toggles every `HALF` cycles. When phase = 1, digits of every field selected in `blink_sel` output `display_char` = 00. Dashes never blink.
- `blank` = 1: `select_light` = 00 and `display_char` = 00. The scan counter, snapshot and blink phase keep running.

## Timing
- Reset values:
  - `select_light` = 00, `display_char` = 00
  - `idx` = 7, prescaler = 0
  - blink phase = 0, blink counter = 0
  - shadows = 00
  - The first scan tick after reset loads idx7 and takes a snapshot.
- First tick occurs `DIV` cycles after `_CR` deasserts. It is registered onto the outputs at the same edge.
- Outputs are registered and change only on scan-tick edges. Between ticks they hold.
- `select_light` is one-hot `1<<idx` whenever `blank` = 0.
- Input-to-display latency: an input change becomes visible at the next idx7 load, at most `8*DIV` cycles later.
- A snapshot tick and a blink toggle on the same cycle both take effect. The new phase applies from the next tick.
- Asserting `_CR` mid-frame forces reset values immediately, with no clock needed.

## Test plan
Bench parameters: `CLK_HZ`=16, `SCAN_HZ`=4 (so `DIV`=4), `BLINK_HZ`=1 (so `HALF`=8).

- Reset then release, hour/min/sec = 12/34/56, `time_mode`=0:
  - outputs are 00/00 for 3 cycles;
  - then ticks every 4 cycles give `select_light` 80,40,20,10,08,04,02,01,80;
  - `display_char` sequence is 60,DA,02,F2,66,02,B6,BE.
- `time_mode`=1, hour=13:
  - idx7 = FC, idx6 = 61 (1 with dp);
  - hour=00 gives idx7 = 60, idx6 = DA, dp clear.
- Change `sec` from 56 to 57 while idx is 3:
  - idx0 of the current frame still shows BE;
  - the next frame's idx0 shows E0.
- `blink_sel`=010:
  - idx4/idx3 show 00 during every 8-cycle window with phase = 1;
  - outside those windows they show normal codes;
  - idx5/idx2 show 02 throughout.
- `min`=8'h3A: idx3 = 00, idx4 = F2. Then `blank`=1 gives 00/00 on the next tick while `idx` keeps advancing.
- Drop `_CR` for 2 cycles mid-frame (idx=2): outputs go to 00 asynchronously, and scanning restarts at idx7, 4 cycles after release.
